// File: rtl/frame_buffer_arbiter_if.sv
// Writer, reader, swap-control and SPRAM-side signals of the frame-buffer arbiter.
// slave is the arbiter's view; master is the view of the blocks around it.
interface frame_buffer_arbiter_if;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ack;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_ack;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        swap_req;
  logic        vsync;
  logic        front_bank;
  logic        swap_pending;
  logic        swap_done;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr, swap_req, vsync, mem_rdata,
    output wr_ack, rd_ack, rd_data, rd_valid, front_bank, swap_pending, swap_done,
           mem_addr, mem_wdata, mem_we
  );

  modport master (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr, swap_req, vsync, mem_rdata,
    input  wr_ack, rd_ack, rd_data, rd_valid, front_bank, swap_pending, swap_done,
           mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/frame_buffer_arbiter.sv
// Round-robin single-port frame-buffer arbiter with double buffering; grants register in 1 cycle, read data 2 cycles after grant.
// Backpressure: a requester holds its request until acked; the writer is stalled while a bank swap is pending.
module frame_buffer_arbiter #(
  parameter int IMAGE_BUF_X     = 4,
  parameter int IMAGE_BUF_Y     = 3,
  parameter int BYTES_PER_PIXEL = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  frame_buffer_arbiter_if.slave bus
);
  localparam int          BANK_SIZE = IMAGE_BUF_X * IMAGE_BUF_Y * BYTES_PER_PIXEL;
  localparam logic [31:0] BANK_BASE = 32'(BANK_SIZE);

  typedef enum logic {IDLE, PENDING} swap_state_t;

  swap_state_t state, state_nxt;
  logic        commit;
  logic        swap_pending;
  logic        front_bank;
  logic        swap_done;

  logic        last_wr;
  logic        wr_elig, rd_elig;
  logic        grant_wr, grant_rd;
  logic        wr_in_range, rd_in_range;
  logic [31:0] front_base, back_base;

  logic        wr_ack, rd_ack, mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        rd_oor1, rd_vld2, rd_oor2;
  logic        rd_valid;
  logic [7:0]  rd_data;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // A swap_req coinciding with vsync in IDLE commits on the same edge.
  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.swap_req) begin
          if (bus.vsync) commit    = 1'b1;
          else           state_nxt = PENDING;
        end
      end
      PENDING: begin
        if (bus.vsync) begin
          commit    = 1'b1;
          state_nxt = IDLE;
        end
      end
    endcase
  end

  assign swap_pending = (state == PENDING);

  // A port whose ack is high this cycle is still holding the request just served.
  always_comb begin
    wr_elig     = bus.wr_req && !wr_ack && !swap_pending;
    rd_elig     = bus.rd_req && !rd_ack;
    grant_wr    = wr_elig && !(rd_elig && last_wr);
    grant_rd    = rd_elig && !grant_wr;
    wr_in_range = bus.wr_addr < BANK_BASE;
    rd_in_range = bus.rd_addr < BANK_BASE;
    front_base  = front_bank ? BANK_BASE : 32'd0;
    back_base   = front_bank ? 32'd0 : BANK_BASE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_wr    <= 1'b1;
      wr_ack     <= 1'b0;
      rd_ack     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 8'd0;
      rd_oor1    <= 1'b0;
      rd_vld2    <= 1'b0;
      rd_oor2    <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= 8'd0;
      front_bank <= 1'b0;
      swap_done  <= 1'b0;
    end else begin
      wr_ack <= grant_wr;
      rd_ack <= grant_rd;
      mem_we <= grant_wr && wr_in_range;
      if (grant_wr && wr_in_range) begin
        mem_addr  <= back_base + bus.wr_addr;
        mem_wdata <= bus.wr_data;
      end else if (grant_rd && rd_in_range) begin
        mem_addr <= front_base + bus.rd_addr;
      end
      if (grant_wr || grant_rd) last_wr <= grant_wr;

      // Out-of-range reads ride the same pipeline so rd_valid timing is uniform.
      rd_oor1  <= grant_rd && !rd_in_range;
      rd_vld2  <= rd_ack;
      rd_oor2  <= rd_oor1;
      rd_valid <= rd_vld2;
      if (rd_vld2) rd_data <= rd_oor2 ? 8'h00 : bus.mem_rdata;

      front_bank <= front_bank ^ commit;
      swap_done  <= commit;
    end
  end

  assign bus.wr_ack       = wr_ack;
  assign bus.rd_ack       = rd_ack;
  assign bus.rd_data      = rd_data;
  assign bus.rd_valid     = rd_valid;
  assign bus.front_bank   = front_bank;
  assign bus.swap_pending = swap_pending;
  assign bus.swap_done    = swap_done;
  assign bus.mem_addr     = mem_addr;
  assign bus.mem_wdata    = mem_wdata;
  assign bus.mem_we       = mem_we;
endmodule

// File: doc/frame_buffer_arbiter.md
# frame_buffer_arbiter

Shares the single-port frame-buffer memory between the UART image streaming writer and the display scan-out reader, and manages double buffering. The writer always targets the back bank, the reader always targets the front bank. A completed stream (`swap_req`, driven by the streaming controller's `streaming_ended`) is committed as a bank swap at the next display `vsync`. The block sits between `image_streaming_controller`, the display timing/scan-out logic and the SPRAM wrapper.

## Interface
- `IMAGE_BUF_X`, 4, image width in pixels
- `IMAGE_BUF_Y`, 3, image height in pixels
- `BYTES_PER_PIXEL`, 2, bytes per pixel; `BANK_SIZE = IMAGE_BUF_X*IMAGE_BUF_Y*BYTES_PER_PIXEL` (24 at defaults)

Ports:
- `clk` in 1: single clock; all logic on posedge
- `reset` in 1: synchronous, active-high
- `wr_req` in 1: writer requests a byte write
- `wr_addr` in 32: logical byte address within the back bank
- `wr_data` in 8: byte to write
- `wr_ack` out 1: one-cycle pulse; write accepted and issued this cycle
- `rd_req` in 1: reader requests a byte read
- `rd_addr` in 32: logical byte address within the front bank
- `rd_ack` out 1: one-cycle pulse; read accepted and issued this cycle
- `rd_data` out 8: read byte (registered)
- `rd_valid` out 1: one-cycle pulse qualifying `rd_data`
- `swap_req` in 1: pulse; back bank holds a complete frame
- `vsync` in 1: pulse; display frame boundary
- `front_bank` out 1: bank currently scanned out
- `swap_pending` out 1: swap requested, not yet committed
- `swap_done` out 1: one-cycle pulse when the swap commits
- `mem_addr` out 32: physical address = bank*BANK_SIZE + logical address
- `mem_wdata` out 8: write data
- `mem_we` out 1: write strobe
- `mem_rdata` in 8: memory read data, valid one cycle after `mem_addr` is issued with `mem_we`=0

## Operation
- **Reset:** every output is 0, including `front_bank`, `swap_pending`, `mem_addr` and `rd_data`. The round-robin pointer is reset to favour the reader.
- **Handshake:** a requester holds req/addr/data stable until it samples ack high. A port is ineligible in any cycle in which its own ack is high. This blocks double issue when req stays asserted for the next transfer. Each port therefore sees at most 1 grant per 2 cycles; the memory can still be busy every cycle.
- **Arbitration:** evaluated at each posedge over eligible requests.
  - Only one port eligible: that port is granted.
  - Both eligible: round-robin; the port not granted last wins.
  - Writer is additionally ineligible while `swap_pending`=1, so a finished frame cannot be overwritten.
- **Write grant (registered, same cycle):** `mem_we`=1, `mem_addr` = (~`front_bank`)*BANK_SIZE + `wr_addr`, `mem_wdata` = `wr_data`, `wr_ack`=1.
- **Read grant (registered, same cycle):** `mem_we`=0, `mem_addr` = `front_bank`*BANK_SIZE + `rd_addr`, `rd_ack`=1.
  - Memory returns data at T+1; `rd_data`/`rd_valid` are registered at T+2.
  - Reads are pipelined, so back-to-back reads each return 2 cycles after their grant.
- **No grant:** `mem_we`=0 and `mem_addr` holds its last value.
- **Out of range (logical address ≥ BANK_SIZE):** the request is still acked.
  - Write: `mem_we` stays 0.
  - Read: no memory access; `rd_data`=8'h00 with `rd_valid` at T+2.
- **Swap FSM, states `IDLE` and `PENDING`:**
  - `IDLE` → `PENDING` on `swap_req`.
  - `PENDING` → `IDLE` on `vsync`: `front_bank` toggles, `swap_done` pulses, `swap_pending` clears, all on the same edge.
  - `swap_req` and `vsync` in the same cycle while in `IDLE`: commit immediately (go directly to `IDLE` with toggle and `swap_done`).
  - `vsync` in `IDLE`: ignored.
  - `swap_req` in `PENDING`: ignored.
- **Bank mapping at swap:** `front_bank` is sampled at grant time. Reads in flight across a swap complete from the old bank.

## Timing
- Write: req sampled at edge N → `wr_ack`/`mem_we` high during cycle N+1.
- Read: `rd_ack` during N+1; `rd_valid` during N+3.
- Swap: `vsync` sampled at edge V → `front_bank` new value, `swap_done` high and `swap_pending` low during cycle V+1. Grants from edge V+1 use the new mapping.
- Writer is eligible again from edge V+1.
- Reset mid-transfer:
  - In-flight `rd_valid` is dropped (no pulse).
  - A pending swap is discarded; `front_bank` returns to 0.
  - Requesters must re-issue.

## Test plan
- **Reset:** hold `reset` 2 cycles with `wr_req`=`rd_req`=1 → all outputs 0 throughout; first grant goes to the reader.
- **Single write:** `front_bank`=0, `wr_addr`=5, `wr_data`=8'hA5 → one cycle later `wr_ack`=1, `mem_we`=1, `mem_addr`=29, `mem_wdata`=8'hA5; exactly one pulse.
- **Single read:** memory model returns addr[7:0]; `rd_addr`=3 → `rd_ack`, `mem_addr`=3, `mem_we`=0; 2 cycles later `rd_valid`=1 with `rd_data`=8'h03.
- **Contention:** both reqs held continuously for 20 cycles with incrementing addresses → grants alternate R,W,R,W; memory busy every cycle; no address issued twice; `rd_data` sequence matches.
- **Swap:** pulse `swap_req`, hold `wr_req`(`wr_addr`=0) → `swap_pending`=1 and no `wr_ack` for 10 cycles. Pulse `vsync` → next cycle `front_bank`=1, `swap_done`=1. Next write issues `mem_addr`=0; reads use base 24. Repeat with `swap_req` and `vsync` coincident → immediate toggle back to 0.
- **Range limit:** `wr_addr`=24 → `wr_ack` pulses, `mem_we` stays 0. `rd_addr`=30 → `rd_valid` with `rd_data`=8'h00 and no `mem_addr` change.
